// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared constants and types for the FP register-file
//               write-back path: register/data widths, the write-back
//               result record and the hardwired-zero register index.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int NUM_FREGS = 1 << ADDR_W;

    // f0 reads as zero and is never written
    localparam logic [ADDR_W-1:0] FREG_ZERO = '0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_result_t;

endpackage
`default_nettype wire

// File: rtl/fpu_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : fpu_wb_arbiter_if
// Description : Bundle of the write-back arbiter's bus signals.
//               Groups: issue (issue_valid/issue_rd/issue_ready),
//               source A (a_valid/a_rd/a_data/a_ready),
//               source B (b_valid/b_rd/b_data/b_ready),
//               hazard query (chk_rs1/2, busy_rs1/2),
//               register-file port (wb_en/wb_rd/wb_data).
//               Modport slave is the arbiter view, master the driver view.
// Revision    : 1.0 - initial release
// ============================================================================
interface fpu_wb_arbiter_if;
    import fpu_pkg::*;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;

    logic              a_valid;
    logic [ADDR_W-1:0] a_rd;
    logic [DATA_W-1:0] a_data;
    logic              a_ready;

    logic              b_valid;
    logic [ADDR_W-1:0] b_rd;
    logic [DATA_W-1:0] b_data;
    logic              b_ready;

    logic [ADDR_W-1:0] chk_rs1;
    logic [ADDR_W-1:0] chk_rs2;
    logic              busy_rs1;
    logic              busy_rs2;

    logic              wb_en;
    logic [ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0] wb_data;

    modport slave (
        input  issue_valid, issue_rd, a_valid, a_rd, a_data,
               b_valid, b_rd, b_data, chk_rs1, chk_rs2,
        output issue_ready, a_ready, b_ready, busy_rs1, busy_rs2,
               wb_en, wb_rd, wb_data
    );

    modport master (
        output issue_valid, issue_rd, a_valid, a_rd, a_data,
               b_valid, b_rd, b_data, chk_rs1, chk_rs2,
        input  issue_ready, a_ready, b_ready, busy_rs1, busy_rs2,
               wb_en, wb_rd, wb_data
    );

endinterface
`default_nettype wire

// File: rtl/fpu_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fpu_wb_fifo
// Description : Synchronous FIFO of write-back results. Head is presented
//               combinationally; full/empty derive from a registered count.
//               Ports: clk, reset (async, active-high), i_push/i_push_data,
//               i_pop, o_full, o_empty, o_head.
//               Caller must not push when full or pop when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_wb_fifo
    import fpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wire        clk,
    input  wire        reset,
    input  wire        i_push,
    input  wb_result_t i_push_data,
    input  wire        i_pop,
    output logic       o_full,
    output logic       o_empty,
    output wb_result_t o_head
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    wb_result_t         r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_full  = (r_count == c_CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fpu_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpu_wb_arbiter
// Description : Write-back arbiter for the FP register file. Serialises
//               pipelined-ALU results (source A) and buffered div/sqrt
//               results (source B, via FIFO) onto one write port with one
//               cycle of latency, with anti-starvation for B, and keeps a
//               pending-write scoreboard for RAW/WAW detection.
//               Ports: clk, reset (async, active-high), bus (slave view of
//               fpu_wb_arbiter_if: issue, A, B, hazard query, wb port).
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_wb_arbiter
    import fpu_pkg::*;
#(
    parameter int B_FIFO_DEPTH = 4,
    parameter int STARVE_MAX   = 3
) (
    input  wire               clk,
    input  wire               reset,
    fpu_wb_arbiter_if.slave   bus
);

    localparam int c_STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_b_push;
    logic                  w_b_pop;
    logic                  w_a_win;
    logic                  w_force_b;
    logic                  w_win_valid;
    logic                  w_issue_ready;
    wb_result_t            w_fifo_head;
    wb_result_t            w_b_res;
    wb_result_t            w_win_res;
    logic [NUM_FREGS-1:0]  w_set_mask;
    logic [NUM_FREGS-1:0]  w_clr_mask;
    logic [NUM_FREGS-1:0]  w_busy_next;

    logic [c_STARVE_W-1:0] r_starve;
    logic [NUM_FREGS-1:0]  r_busy;
    logic                  r_wb_en;
    logic [ADDR_W-1:0]     r_wb_rd;
    logic [DATA_W-1:0]     r_wb_data;

    // ---------------- source-B buffer ----------------
    assign w_b_res  = {bus.b_rd, bus.b_data};
    assign w_b_push = bus.b_valid && !w_fifo_full;

    fpu_wb_fifo #(
        .DEPTH (B_FIFO_DEPTH)
    ) u_b_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_b_push),
        .i_push_data (w_b_res),
        .i_pop       (w_b_pop),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_head      (w_fifo_head)
    );

    // ---------------- arbitration ----------------
    // B is forced only after STARVE_MAX consecutive A wins over a waiting B
    assign w_force_b   = !w_fifo_empty && (r_starve == c_STARVE_MAX);
    assign w_a_win     = bus.a_valid && !w_force_b;
    assign w_b_pop     = !w_fifo_empty && (!bus.a_valid || w_force_b);
    assign w_win_valid = w_a_win || w_b_pop;
    assign w_win_res   = w_a_win ? wb_result_t'({bus.a_rd, bus.a_data}) : w_fifo_head;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_starve <= '0;
        end else if (w_fifo_empty || w_b_pop) begin
            r_starve <= '0;
        end else if (w_a_win && (r_starve != c_STARVE_MAX)) begin
            r_starve <= r_starve + 1'b1;
        end
    end

    // ---------------- registered write port ----------------
    // An rd==0 winner completes its handshake but never enables the write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wb_en   <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
        end else if (w_win_valid) begin
            r_wb_en   <= (w_win_res.rd != FREG_ZERO);
            r_wb_rd   <= w_win_res.rd;
            r_wb_data <= w_win_res.data;
        end else begin
            r_wb_en   <= 1'b0;
        end
    end

    // ---------------- scoreboard ----------------
    assign w_issue_ready = !r_busy[bus.issue_rd] || (bus.issue_rd == FREG_ZERO);

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (bus.issue_valid && w_issue_ready && (bus.issue_rd != FREG_ZERO))
            w_set_mask[bus.issue_rd] = 1'b1;
        if (r_wb_en)
            w_clr_mask[r_wb_rd] = 1'b1;
    end

    // Set is applied after clear so a same-cycle re-issue keeps the bit
    assign w_busy_next = (r_busy & ~w_clr_mask) | w_set_mask;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_busy <= '0;
        else       r_busy <= {w_busy_next[NUM_FREGS-1:1], 1'b0};
    end

    // ---------------- outputs ----------------
    assign bus.issue_ready = w_issue_ready;
    assign bus.a_ready     = w_a_win;
    assign bus.b_ready     = !w_fifo_full;
    // A write sitting on the port still counts as pending (no bypass)
    assign bus.busy_rs1    = (bus.chk_rs1 != FREG_ZERO) &&
                             (r_busy[bus.chk_rs1] || (r_wb_en && (r_wb_rd == bus.chk_rs1)));
    assign bus.busy_rs2    = (bus.chk_rs2 != FREG_ZERO) &&
                             (r_busy[bus.chk_rs2] || (r_wb_en && (r_wb_rd == bus.chk_rs2)));
    assign bus.wb_en       = r_wb_en;
    assign bus.wb_rd       = r_wb_rd;
    assign bus.wb_data     = r_wb_data;

endmodule
`default_nettype wire

// File: doc/fpu_wb_arbiter.md
Name: fpu_wb_arbiter

Overview:
Write-back side of the FP register file. Collects results from the pipelined FP ALU (source A) and the iterative div/sqrt unit (source B) and serialises them onto the single register-file write port (wb_en/wb_rd/wb_data). Buffers B results in a small FIFO. Keeps a pending-write scoreboard so issue logic can detect RAW/WAW hazards on f-registers.

Parameters:
DATA_W, 32, FP register width
ADDR_W, 5, register index width (32 registers)
B_FIFO_DEPTH, 4, source-B result buffer entries (power of two, >=2)
STARVE_MAX, 3, consecutive A wins before a non-empty B FIFO is forced

Ports:
clk  in  1  clock
reset  in  1  reset
issue_valid  in  1  FP instruction with f-dest is issuing
issue_rd  in  ADDR_W  its destination register
issue_ready  out  1  issue permitted (no WAW on issue_rd)
a_valid  in  1  source A result valid
a_rd  in  ADDR_W  source A destination
a_data  in  DATA_W  source A result
a_ready  out  1  source A result accepted this cycle
b_valid  in  1  source B result valid
b_rd  in  ADDR_W  source B destination
b_data  in  DATA_W  source B result
b_ready  out  1  FIFO not full
chk_rs1  in  ADDR_W  hazard query 1
chk_rs2  in  ADDR_W  hazard query 2
busy_rs1  out  1  chk_rs1 has pending write
busy_rs2  out  1  chk_rs2 has pending write
wb_en  out  1  register-file write enable
wb_rd  out  ADDR_W  register-file write address
wb_data  out  DATA_W  register-file write data

Behaviour:
- Reset asynchronous, active-high; clock clk. On reset: wb_en=0, wb_rd=0, wb_data=0, FIFO empty, starvation counter=0, scoreboard all clear. Reset mid-operation discards FIFO contents and pending bits.
- B FIFO: push when b_valid && b_ready; b_ready = !full (registered count). Push while full is impossible by handshake; push and pop in the same cycle when full is not allowed (b_ready already low).
- Arbitration per cycle, one winner:
  - FIFO empty: A wins if a_valid.
  - FIFO non-empty, a_valid=0: FIFO head pops.
  - FIFO non-empty, a_valid=1: A wins unless starve_cnt==STARVE_MAX, then FIFO head pops and A stalls (a_ready=0).
  - a_ready = a_valid && A is winner (combinational).
- starve_cnt: increments when A wins while FIFO non-empty; clears on any FIFO pop or when FIFO empty; saturates at STARVE_MAX.
- Output stage registered: the winner appears on wb_en/wb_rd/wb_data on the next clock edge (1-cycle latency). wb_en low for idle cycles. A winner with rd==0 is consumed (handshake completes) but wb_en stays 0; f0 is never written.
- Scoreboard: 32 busy bits, bit 0 hardwired 0.
  - Set busy[issue_rd] on issue_valid && issue_ready, rd!=0.
  - Clear busy[wb_rd] on the edge after wb_en is high (i.e., when the register file commits).
  - Same register set and cleared in the same cycle: set wins.
  - issue_ready = !busy[issue_rd] || issue_rd==0 (combinational).
  - busy_rs1/2 = busy[chk_rsN] || (wb_en && wb_rd==chk_rsN && chk_rsN!=0); write in flight counts as busy, no bypass.
- Results arriving for a non-busy register are still written (no checking); the scoreboard clear is then a no-op.
- FIFO pointers wrap modulo B_FIFO_DEPTH; count width log2(depth)+1.

Decomposition:
- Shared package fpu_pkg: DATA_W/ADDR_W constants, wb result struct {rd, data}, FREG_ZERO index constant.
- One sub-module: fpu_wb_fifo (sync FIFO, push/pop/full/empty/head), instantiated for source B.

Test Plan:
- Reset then A alone: a_valid=1, a_rd=3, a_data=0x3F800000 -> a_ready=1 same cycle; next cycle wb_en=1, wb_rd=3, wb_data=0x3F800000; busy[3] cleared one cycle later.
- WAW block: issue rd=5 -> busy_rs1(chk_rs1=5)=1, second issue rd=5 sees issue_ready=0 until write of f5 committed.
- Starvation: push B rd=7 data=0x40000000, hold a_valid=1 continuously -> A wins 3 cycles, 4th cycle a_ready=0 and wb shows rd=7 next cycle; A resumes after.
- FIFO full: push 4 B results with a_valid=1 and STARVE_MAX large enough -> b_ready=0 after 4th push; pops drain in push order (rd 8,9,10,11).
- rd=0: A result rd=0 -> a_ready=1, wb_en stays 0; issue rd=0 -> issue_ready=1, busy_rs1(0)=0.
- Reset mid-drain: 2 entries in FIFO, busy bits set, assert reset -> wb_en=0 immediately, b_ready=1, all busy_rs=0 after release.
